// File: rtl/data_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared definitions for the data memory responder: FSM state encoding,
// default geometry/latency and the address-error helper.
// ---------------------------------------------------------------------------
package data_mem_responder_pkg;

   // Default number of 32-bit words held by the array.
   localparam int DM_DEPTH_DEFAULT   = 256;
   // Default edges from request acceptance to response (legal 1..15).
   localparam int DM_LATENCY_DEFAULT = 2;
   // Latency counter width; wide enough for LATENCY-1 up to 14.
   localparam int DM_CNT_W           = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } dm_state_e;

   // A byte address is in error when it is not word aligned or when its
   // word index falls outside the array.
   function automatic logic dm_addr_err(input logic [15:0] addr, input int unsigned depth);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr[1:0] != 2'b00);
      out_of_range = ({18'd0, addr[15:2]} >= depth);
      return misaligned | out_of_range;
   endfunction

endpackage

// File: rtl/data_mem_responder_dm_array.sv
// ---------------------------------------------------------------------------
// dm_array
// Single-port word storage: synchronous write, combinational read, no reset
// (contents survive a responder reset).
// Ports:
//   clk      - clock, write happens on its rising edge
//   i_we     - write enable
//   i_idx    - word index shared by read and write
//   i_wdata  - write data
//   o_rdata  - combinational read data at i_idx
// ---------------------------------------------------------------------------
module dm_array
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH = DM_DEPTH_DEFAULT,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_idx,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];

   // Storage write port.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Fixed-latency load/store responder for a CPU data port. One request is in
// flight at a time: IDLE accepts, BUSY counts down the latency, RESP holds
// the response until the requester takes it.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_ready - request handshake (ready only in IDLE)
//   req_write           - 1 = store, 0 = load
//   req_addr            - byte address (word aligned expected)
//   req_wdata           - store data
//   rsp_valid/rsp_ready - response handshake
//   rsp_rdata           - load data, 0 for stores and errored requests
//   rsp_err             - misaligned or out-of-range request
// ---------------------------------------------------------------------------
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH   = DM_DEPTH_DEFAULT,
   parameter int LATENCY = DM_LATENCY_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [DM_CNT_W-1:0] CNT_LOAD = DM_CNT_W'(LATENCY - 1);

   dm_state_e           r_state;
   logic [DM_CNT_W-1:0] r_cnt;
   logic                r_write;
   logic [15:0]         r_addr;
   logic [31:0]         r_wdata;
   logic                r_req_ready;
   logic                r_rsp_valid;
   logic [31:0]         r_rsp_rdata;
   logic                r_rsp_err;

   logic                w_err;
   logic                w_last;
   logic                w_we;
   logic [AW-1:0]       w_idx;
   logic [31:0]         w_mem_rdata;

   // Error is judged from the captured address, never the live request bus.
   assign w_err  = dm_addr_err(r_addr, DEPTH);
   // Final BUSY edge: the one where the array is written / read out.
   assign w_last = (r_state == ST_BUSY) && (r_cnt == {DM_CNT_W{1'b0}});
   assign w_we   = w_last && r_write && !w_err;
   assign w_idx  = r_addr[AW+1:2];

   dm_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_dm_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_idx   (w_idx),
      .i_wdata (r_wdata),
      .o_rdata (w_mem_rdata)
   );

   // Request/response FSM with registered handshake and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= {DM_CNT_W{1'b0}};
         r_write     <= 1'b0;
         r_addr      <= 16'd0;
         r_wdata     <= 32'd0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_write     <= req_write;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_cnt       <= CNT_LOAD;
                  r_req_ready <= 1'b0;
                  r_state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (r_cnt == {DM_CNT_W{1'b0}}) begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_err;
                  // Only a clean load returns array data.
                  r_rsp_rdata <= (!w_err && !r_write) ? w_mem_rdata : 32'd0;
               end else begin
                  r_cnt <= r_cnt - {{(DM_CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_RESP: begin
               // Response fields are frozen here until the requester takes them.
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               // Unreachable encoding: fall back to a clean idle.
               r_state     <= ST_IDLE;
               r_cnt       <= {DM_CNT_W{1'b0}};
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
               r_rsp_rdata <= 32'd0;
               r_rsp_err   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Randomized and directed stimulus against a transaction-level model of the
// responder (memory array + "response due LATENCY edges after acceptance").
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

   localparam int LAT = 2;
   localparam int DEP = 256;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_vec = 0;
   int n_err = 0;

   // model state
   logic [31:0] mem [DEP];
   logic [31:0] pre [DEP];
   bit          m_pend = 1'b0;
   bit          m_rsp  = 1'b0;
   int          m_acc  = 0;
   bit          m_w;
   logic [15:0] m_a;
   logic [31:0] m_d;
   logic [31:0] m_rdata = 32'd0;
   logic        m_err   = 1'b0;
   int          cyc     = 0;
   int          acc_q [$];

   data_mem_responder #(.DEPTH(DEP), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit bad_addr(input logic [15:0] a);
      return (a % 4 != 0) || ((a / 4) >= DEP);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction model: one request in flight, response due LAT edges after
   // acceptance, released by rsp_ready, next acceptance on a later edge.
   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
         m_pend = 1'b0;
         m_rsp  = 1'b0;
      end else if (m_rsp) begin
         if (rsp_ready) begin
            m_rsp  = 1'b0;
            m_pend = 1'b0;
         end
      end else if (m_pend) begin
         if (cyc == m_acc + LAT) begin
            m_rsp = 1'b1;
            m_err = bad_addr(m_a);
            if (m_w) begin
               m_rdata = 32'd0;
               if (!m_err) mem[m_a / 4] = m_d;
            end else begin
               m_rdata = m_err ? 32'd0 : mem[m_a / 4];
            end
         end
      end else if (req_valid) begin
         m_pend = 1'b1;
         m_acc  = cyc;
         m_w    = req_write;
         m_a    = req_addr;
         m_d    = req_wdata;
         acc_q.push_back(cyc);
      end
   end

   // Cycle-by-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
         check("req_ready", {31'd0, req_ready}, {31'd0, !m_pend});
         check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rsp});
         if (m_rsp) begin
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
         end
      end
   end

   // One request/response; starts and ends on a falling edge.
   task automatic xact(input bit w, input logic [15:0] a, input logic [31:0] d, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
      int n;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      rsp_ready = 1'b0;
      n = 0;
      while (req_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      // scramble the bus to prove the request was captured
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = $urandom;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 40) check("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
      rd = rsp_rdata;
      er = rsp_err;
      for (int h = 0; h < hold; h++) begin
         check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;

   initial begin
      int s0;
      int n;
      logic [15:0] a;
      logic [31:0] v;
      bit nxt_w;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 16'd0;
      req_wdata = 32'd0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

      // fill every word with known data
      for (int i = 0; i < DEP; i++) begin
         pre[i] = $urandom;
         xact(1'b1, 16'(i * 4), pre[i], 0, rd, er, lat);
      end

      // store then load, latency and data
      xact(1'b1, 16'h0010, 32'hDEADBEEF, 0, rd, er, lat);
      check("st10_lat", 32'(lat), 32'd2);
      check("st10_rdata", rd, 32'd0);
      check("st10_err", {31'd0, er}, 32'd0);
      xact(1'b0, 16'h0010, 32'd0, 0, rd, er, lat);
      check("ld10_lat", 32'(lat), 32'd2);
      check("ld10_rdata", rd, 32'hDEADBEEF);
      check("ld10_err", {31'd0, er}, 32'd0);

      // misaligned accesses
      xact(1'b0, 16'h0013, 32'd0, 0, rd, er, lat);
      check("ld13_err", {31'd0, er}, 32'd1);
      check("ld13_rdata", rd, 32'd0);
      xact(1'b1, 16'h0012, 32'hCAFEF00D, 0, rd, er, lat);
      check("st12_err", {31'd0, er}, 32'd1);
      xact(1'b0, 16'h0010, 32'd0, 0, rd, er, lat);
      check("ld10_after_st12", rd, 32'hDEADBEEF);

      // out of range store
      xact(1'b1, 16'h0400, 32'h55AA55AA, 0, rd, er, lat);
      check("st400_err", {31'd0, er}, 32'd1);
      xact(1'b0, 16'h0000, 32'd0, 0, rd, er, lat);
      check("ld0_after_st400", rd, pre[0]);
      check("ld0_err", {31'd0, er}, 32'd0);
      xact(1'b0, 16'h03FC, 32'd0, 0, rd, er, lat);
      check("ld3fc_err", {31'd0, er}, 32'd0);

      // held response, then immediate next request
      s0 = acc_q.size();
      xact(1'b0, 16'h0010, 32'd0, 5, rd, er, lat);
      check("hold_rdata", rd, 32'hDEADBEEF);
      xact(1'b0, 16'h0014, 32'd0, 0, rd, er, lat);
      check("hold_rdata2", rd, pre[5]);
      check("hold_spacing", 32'(acc_q[s0 + 1] - acc_q[s0]), 32'd9);

      // reset one cycle into BUSY of a store
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0020;
      req_wdata = 32'h12345678;
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("abort_rsp_rdata", rsp_rdata, 32'd0);
      check("abort_rsp_err", {31'd0, rsp_err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("abort_req_ready", {31'd0, req_ready}, 32'd1);
      xact(1'b0, 16'h0020, 32'd0, 0, rd, er, lat);
      check("abort_old_value", rd, pre[8]);

      // continuous valid/ready, alternating store/load on the same word
      s0 = acc_q.size();
      n  = s0;
      a  = 16'(16'd40 * 16'd4);
      v  = $urandom;
      nxt_w = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = a;
      req_wdata = v;
      for (int c = 0; c < 42; c++) begin
         @(negedge clk);
         if (acc_q.size() != n) begin
            n = acc_q.size();
            if (nxt_w) begin
               a = a + 16'd4;
               v = $urandom;
            end
            req_write = nxt_w;
            req_addr  = a;
            req_wdata = v;
            nxt_w = !nxt_w;
         end
      end
      req_valid = 1'b0;
      n = 0;
      while (m_pend && n < 40) begin
         @(negedge clk);
         n++;
      end
      rsp_ready = 1'b0;
      for (int i = s0 + 1; i < acc_q.size(); i++) begin
         check("b2b_spacing", 32'(acc_q[i] - acc_q[i - 1]), 32'(LAT + 2));
      end

      // random traffic
      for (int t = 0; t < 120; t++) begin
         int r;
         r = int'($urandom_range(0, 7));
         case (r)
            0: a = 16'($urandom);
            1: a = ($urandom_range(0, 1) == 0) ? 16'h03FC : 16'h0400;
            default: a = 16'($urandom_range(0, DEP - 1) * 4);
         endcase
         xact(1'($urandom), a, $urandom, int'($urandom_range(0, 3)), rd, er, lat);
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DEPTH, 256, number of 32-bit words stored.
REQ-002 Parameters SHALL include: LATENCY, 2, clock edges from request acceptance to response (legal 1..15).
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-005 Port req_valid SHALL be input, 1 bit: the CPU side presents a load/store request.
REQ-006 Port req_ready SHALL be output, 1 bit: the block can accept a request this cycle.
REQ-007 Port req_write SHALL be input, 1 bit: 1 = store, 0 = load.
REQ-008 Port req_addr SHALL be input, 16 bits: byte address, word-aligned expected.
REQ-009 Port req_wdata SHALL be input, 32 bits: store data.
REQ-010 Port rsp_valid SHALL be output, 1 bit: response available.
REQ-011 Port rsp_ready SHALL be input, 1 bit: the requester accepts the response.
REQ-012 Port rsp_rdata SHALL be output, 32 bits: load data; 0 for stores and errored requests.
REQ-013 Port rsp_err SHALL be output, 1 bit: the request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have three states, IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_write, req_addr and req_wdata SHALL be captured into internal registers on that edge.
REQ-016 On acceptance the FSM SHALL go IDLE->BUSY and load the latency counter with LATENCY-1.
REQ-017 In BUSY the counter SHALL decrement each edge; on the edge where it equals 0, the FSM SHALL go BUSY->RESP.
REQ-018 For acceptance on edge k, rsp_valid SHALL rise after edge k+LATENCY.
REQ-019 The block SHALL flag an error when captured addr[1:0]!=0 or addr[15:2]>=DEPTH; the error SHALL be evaluated from the captured address.
REQ-020 On the BUSY->RESP edge, a non-errored store SHALL write mem[addr[15:2]]<=wdata; an errored store SHALL leave memory unchanged.
REQ-021 On the BUSY->RESP edge, a non-errored load SHALL register mem[addr[15:2]] into rsp_rdata; all other cases SHALL register 0.
REQ-022 rsp_rdata and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-023 In RESP with rsp_ready=1, the FSM SHALL go RESP->IDLE on that edge and rsp_valid SHALL fall.
REQ-024 rsp_ready=1 in the first RESP cycle SHALL give a single-cycle response.
REQ-025 Back-to-back operation: a new request SHALL be accepted no earlier than the edge after RESP->IDLE; minimum request spacing SHALL be LATENCY+2 edges.
REQ-026 req_valid=1 while not in IDLE SHALL be ignored; the requester holds it until req_ready.
REQ-027 A load following a store to the same word SHALL return the stored value.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 after release.
REQ-029 Reset during BUSY SHALL abort the operation; a pending store SHALL NOT be committed.
REQ-030 Reset SHALL NOT clear memory contents.

Structure
REQ-031 The FSM state encoding, default DEPTH and default LATENCY SHALL live in the shared CPU package.
REQ-032 The storage SHALL be one sub-module, dm_array: single-port array with synchronous write and combinational read, word index input, no reset.

Verification
REQ-033 Store 0xDEADBEEF to addr 0x0010, then load 0x0010 with LATENCY=2 -> rsp_valid rises after edge k+2 for each request; load returns 0xDEADBEEF with rsp_err=0.
REQ-034 Load addr 0x0013 -> rsp_err=1, rsp_rdata=0; a store to 0x0012 leaves word 4 unchanged.
REQ-035 Store to addr 0x0400 with DEPTH=256 -> rsp_err=1; a subsequent load of 0x0000 is unaffected.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0; a new request is accepted on the edge after the handshake completes.
REQ-037 Assert rst_n=0 one cycle into BUSY for a store of 0x12345678 to 0x0020 -> outputs clear immediately; a load of 0x0020 afterwards returns the old value.
REQ-038 Keep rsp_ready=1 and req_valid=1 continuously with alternating stores and loads -> acceptances are exactly LATENCY+2 edges apart and the data is correct.
